// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of mem_port_arbiter.
// When ARB_TIMEOUT_EN is defined, the i_err/d_err flags are also present.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_rd_wr;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data_in;
  logic [1:0]        m_access_size;
  logic              m_rd_wr;
  logic              m_enable;
  logic [DATA_W-1:0] m_data_out;
  logic              m_busy;
`ifdef ARB_TIMEOUT_EN
  logic              i_err;
  logic              d_err;
`endif

  modport master (
`ifdef ARB_TIMEOUT_EN
    output i_err, d_err,
`endif
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_rd_wr, d_size, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_addr, m_data_in, m_access_size, m_rd_wr, m_enable,
    input  m_data_out, m_busy
  );

  modport slave (
`ifdef ARB_TIMEOUT_EN
    input  i_err, d_err,
`endif
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_rd_wr, d_size, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_data_in, m_access_size, m_rd_wr, m_enable,
    output m_data_out, m_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch and data paths.
// Define ARB_TIMEOUT_EN to abort WAIT after TIMEOUT busy cycles (err + 32'hDEADBEEF).
//
// state    | meaning
// IDLE     | grants offered, request fields latched on acceptance
// ISSUE    | first memory cycle, m_busy ignored
// WAIT     | memory outputs held until m_busy drops (or timeout)
// RESP     | owner's rvalid pulse, memory released
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  state_t            state;
  logic              last_d;
  logic              owner_d;
  logic              i_gnt_c;
  logic              d_gnt_c;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_data_in_q;
  logic [1:0]        m_size_q;
  logic              m_rd_wr_q;
  logic              m_enable_q;
  logic              i_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

`ifdef ARB_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMR_W-1:0] wait_tmr;
  logic             i_err_q;
  logic             d_err_q;

  assign bus.i_err = i_err_q;
  assign bus.d_err = d_err_q;
`endif

  // On a tie the requester that did not win last time is served.
  always_comb begin
    i_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (state == ST_IDLE) begin
      if (bus.d_req && (!bus.i_req || !last_d))
        d_gnt_c = 1'b1;
      else if (bus.i_req)
        i_gnt_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      last_d      <= 1'b0;
      owner_d     <= 1'b0;
      m_addr_q    <= '0;
      m_data_in_q <= '0;
      m_size_q    <= '0;
      m_rd_wr_q   <= 1'b1;
      m_enable_q  <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_tmr    <= '0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
`endif
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (d_gnt_c) begin
            owner_d     <= 1'b1;
            last_d      <= 1'b1;
            m_addr_q    <= bus.d_addr;
            m_data_in_q <= bus.d_wdata;
            m_size_q    <= bus.d_size;
            m_rd_wr_q   <= bus.d_rd_wr;
            m_enable_q  <= 1'b1;
            state       <= ST_ISSUE;
          end else if (i_gnt_c) begin
            owner_d    <= 1'b0;
            last_d     <= 1'b0;
            m_addr_q   <= bus.i_addr;
            m_size_q   <= SZ_WORD;
            m_rd_wr_q  <= 1'b1;
            m_enable_q <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
          wait_tmr <= TMR_W'(TIMEOUT - 1);
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!bus.m_busy) begin
            if (!owner_d)
              i_rdata_q <= bus.m_data_out;
            else if (m_rd_wr_q)
              d_rdata_q <= bus.m_data_out;
            i_rvalid_q <= !owner_d;
            d_rvalid_q <= owner_d;
            m_enable_q <= 1'b0;
            m_rd_wr_q  <= 1'b1;
            state      <= ST_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_tmr == '0) begin
            if (!owner_d)
              i_rdata_q <= DATA_W'(32'hDEADBEEF);
            else
              d_rdata_q <= DATA_W'(32'hDEADBEEF);
            i_rvalid_q <= !owner_d;
            d_rvalid_q <= owner_d;
            i_err_q    <= !owner_d;
            d_err_q    <= owner_d;
            m_enable_q <= 1'b0;
            m_rd_wr_q  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wait_tmr <= wait_tmr - TMR_W'(1);
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_gnt         = i_gnt_c;
  assign bus.d_gnt         = d_gnt_c;
  assign bus.i_rvalid      = i_rvalid_q;
  assign bus.d_rvalid      = d_rvalid_q;
  assign bus.i_rdata       = i_rdata_q;
  assign bus.d_rdata       = d_rdata_q;
  assign bus.m_addr        = m_addr_q;
  assign bus.m_data_in     = m_data_in_q;
  assign bus.m_access_size = m_size_q;
  assign bus.m_rd_wr       = m_rd_wr_q;
  assign bus.m_enable      = m_enable_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]  mem_wr [0:255];
  logic [255:0] wr_ok;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h2408_0005;
      32'h080: return 32'hA5A5_0001;
      32'h084: return 32'h5A5A_0002;
      default: return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)
      wr_ok <= '0;
    else if (bus.m_enable && !bus.m_rd_wr && !bus.m_busy) begin
      mem_wr[bus.m_addr[9:2]] <= bus.m_data_in;
      wr_ok[bus.m_addr[9:2]]  <= 1'b1;
    end
  end

  assign bus.m_data_out = wr_ok[bus.m_addr[9:2]] ? mem_wr[bus.m_addr[9:2]]
                                                 : rom_word(bus.m_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Counts falling edges from the grant cycle until any rvalid, bounded.
  task automatic wait_rv(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.i_rvalid || bus.d_rvalid) && n < 60);
  endtask

  int lat;
  logic exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_rd_wr = 1'b1;
    bus.d_size  = 2'b10;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_busy  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_i_gnt", bus.i_gnt, 0);
    chk("rst_m_enable", bus.m_enable, 0);
    chk("rst_m_rd_wr", bus.m_rd_wr, 1);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    reset = 1'b1;

    // single fetch
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    #1 chk("t1_gnt", {bus.i_gnt, bus.d_gnt}, 2'b10);
    @(negedge clk);
    bus.i_req = 1'b0;
    chk("t1_issue", {bus.m_enable, bus.m_rd_wr, bus.m_access_size}, 4'b1110);
    chk("t1_m_addr", bus.m_addr, 32'h100);
    @(negedge clk);
    chk("t1_wait_rv", bus.i_rvalid, 0);
    @(negedge clk);
    chk("t1_i_rvalid", {bus.i_rvalid, bus.d_rvalid, bus.m_enable}, 3'b100);
    chk("t1_i_rdata", bus.i_rdata, 32'h2408_0005);
    @(negedge clk);
    chk("t1_rv_pulse", bus.i_rvalid, 0);

    // simultaneous pairs alternate, D first after an I win
    bus.i_addr = 32'h84; bus.d_addr = 32'h80; bus.d_rd_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      #1 chk("t2_gnt", {bus.d_gnt, bus.i_gnt}, {exp_d[k], !exp_d[k]});
      @(negedge clk);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      wait_rv(lat);
      chk("t2_lat", lat, 2);
      chk("t2_owner", {bus.d_rvalid, bus.i_rvalid}, {exp_d[k], !exp_d[k]});
      chk("t2_data", exp_d[k] ? bus.d_rdata : bus.i_rdata,
          exp_d[k] ? 32'hA5A5_0001 : 32'h5A5A_0002);
      @(negedge clk);
    end

    // write, then read back
    bus.d_req = 1'b1; bus.d_rd_wr = 1'b0; bus.d_addr = 32'h40; bus.d_wdata = 32'hCAFE_F00D;
    #1 chk("t3_gnt", bus.d_gnt, 1);
    @(negedge clk);
    bus.d_req = 1'b0;
    chk("t3_issue", {bus.m_enable, bus.m_rd_wr}, 2'b10);
    chk("t3_wdata", bus.m_data_in, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t3_wait_wr", bus.m_rd_wr, 0);
    @(negedge clk);
    chk("t3_ack", {bus.d_rvalid, bus.m_rd_wr, bus.m_enable}, 3'b110);
    chk("t3_rdata_kept", bus.d_rdata, 32'hA5A5_0001);
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_rd_wr = 1'b1;
    #1 chk("t3_rd_gnt", bus.d_gnt, 1);
    @(negedge clk);
    bus.d_req = 1'b0;
    wait_rv(lat);
    chk("t3_readback", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'hCAFE_F00D});
    @(negedge clk);

    // five busy cycles in WAIT
    bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.m_busy = 1'b1;
    #1 chk("t4_gnt", bus.i_gnt, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.i_req = 1'b0;
      if (k == 7) bus.m_busy = 1'b0;
      chk("t4_hold", {bus.m_enable, bus.m_rd_wr, bus.m_addr, bus.i_rvalid},
          {1'b1, 1'b1, 32'h100, 1'b0});
    end
    @(negedge clk);
    chk("t4_rv8", {bus.i_rvalid, bus.i_rdata}, {1'b1, 32'h2408_0005});
    @(negedge clk);

    // reset during WAIT of a write; last winner was I, so D wins the tie
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_rd_wr = 1'b0;
    bus.d_addr = 32'h44; bus.m_busy = 1'b1;
    #1 chk("t5_gnt", {bus.d_gnt, bus.i_gnt}, 2'b10);
    @(negedge clk);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("t5_wait", {bus.m_enable, bus.m_rd_wr}, 2'b10);
    #2 reset = 1'b0;
    #1 chk("t5_async", {bus.m_enable, bus.m_rd_wr}, 2'b01);
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_rv", {bus.i_rvalid, bus.d_rvalid}, 0);
    end
    reset = 1'b1; bus.m_busy = 1'b0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_rd_wr = 1'b1; bus.d_addr = 32'h80;
    #1 chk("t5_tie_d", {bus.d_gnt, bus.i_gnt}, 2'b10);
    @(negedge clk);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    wait_rv(lat);
    chk("t5_read", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'hA5A5_0001});
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // stuck busy: ISSUE + 16 WAIT cycles, RESP on cycle 18 after grant
    bus.d_req = 1'b1; bus.m_busy = 1'b1;
    @(negedge clk);
    bus.d_req = 1'b0;
    wait_rv(lat);
    chk("t6_lat", lat, 17);
    chk("t6_err", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {2'b11, 32'hDEAD_BEEF});
    bus.m_busy = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1;
    @(negedge clk);
    bus.d_req = 1'b0;
    wait_rv(lat);
    chk("t6_ok", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {2'b10, 32'hA5A5_0001});
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported `memory` instance between the instruction-fetch path and the data load/store path of the multi-cycle MIPS core. It arbitrates between the two requesters round-robin and registers the winning request. It then drives the memory port through an issue/wait/response sequence, holding through `busy`, and returns read data or a write acknowledge to the requester that was granted.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of all data buses
TIMEOUT, 16, maximum WAIT cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held until granted
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch granted this cycle
i_rvalid  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  DATA_W  fetched word
d_req  in  1  data request; held until granted
d_rd_wr  in  1  1 = read, 0 = write (memory convention)
d_size  in  2  access size code (sz_word etc.)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data granted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid or store done
d_rdata  out  DATA_W  load data
m_addr  out  ADDR_W  memory address
m_data_in  out  DATA_W  memory write data
m_access_size  out  2  memory access size
m_rd_wr  out  1  memory direction
m_enable  out  1  memory enable
m_data_out  in  DATA_W  memory read data
m_busy  in  1  memory busy

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - i_gnt, d_gnt, i_rvalid, d_rvalid, m_enable = 0.
  - m_rd_wr = 1.
  - All buses = 0.
  - last_winner = I, so D wins the first tie.
- Grants:
  - Grants are combinational and are asserted only in IDLE.
  - With one requester, that requester is granted.
  - With both requesting, the requester that is not last_winner is granted.
  - At most one gnt is high in any cycle.
- Acceptance:
  - A request is accepted at the clock edge where req && gnt.
  - At that edge the arbiter latches the request fields (fetch is forced to rd_wr = 1 and size sz_word), updates last_winner, and moves to ISSUE.
  - A req still high in the cycle after acceptance is a new request.
- ISSUE (1 cycle):
  - m_enable = 1; memory outputs carry the latched fields.
  - Next state is always WAIT; m_busy is ignored in ISSUE.
- WAIT:
  - Memory outputs are held.
  - While m_busy = 1, stay in WAIT.
  - When m_busy = 0, capture m_data_out into the owner's rdata register and go to RESP.
- RESP (1 cycle):
  - The owner's rvalid = 1; m_enable = 0; m_rd_wr = 1.
  - Next state is IDLE. A new grant is possible in the cycle after RESP.
- Latency: rvalid is asserted 3 cycles after the acceptance edge when m_busy stays 0. Each busy cycle in WAIT adds 1.
- Write safety: m_rd_wr = 0 only in ISSUE or WAIT of a data write. At all other times it is 1.
- rdata holds its value until the next capture for that port. For writes, d_rdata is unchanged and d_rvalid acts as the acknowledge.
- Asynchronous reset mid-transaction:
  - Immediately go to IDLE, with m_enable = 0, m_rd_wr = 1, and no rvalid.
  - The requester must re-issue.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - Adds ports i_err and d_err (out, 1).
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If the counter reaches TIMEOUT with m_busy still 1, go to RESP with the owner's rvalid = 1 and err = 1, and rdata = 32'hDEADBEEF.
  - err is 0 on normal completion.
- Undefined: no err ports, no counter; WAIT persists indefinitely.

Test Plan:
1. After reset, i_req = 1, i_addr = 0x100, memory word 0x24080005, m_busy = 0 → i_gnt = 1 in the same cycle; next cycle m_enable = 1, m_addr = 0x100, m_rd_wr = 1; i_rvalid = 1 with i_rdata = 0x24080005 three cycles after acceptance; d_rvalid stays 0.
2. i_req and d_req both held from reset → d_gnt first, then i_gnt at the next IDLE; a repeated simultaneous pair then grants I and D alternately.
3. d_req write: d_rd_wr = 0, d_addr = 0x40, d_wdata = 0xCAFEF00D → m_rd_wr = 0 only during ISSUE/WAIT; d_rvalid pulse; a subsequent read of 0x40 returns 0xCAFEF00D.
4. Read with m_busy held high for 5 WAIT cycles → rvalid at acceptance + 8; memory outputs stable throughout WAIT.
5. reset driven low during WAIT of a write → m_enable = 0 and m_rd_wr = 1 without waiting for a clock edge; no rvalid; after release, state is IDLE and D wins the next tie.
6. With ARB_TIMEOUT_EN, TIMEOUT = 16, m_busy stuck at 1 → d_rvalid = 1, d_err = 1, d_rdata = 0xDEADBEEF after 16 WAIT cycles; next request proceeds normally with err = 0.
